mem_write_buffer: RTL and testbench

//  Posted-write buffer between dcache_controller's 256-bit memory port and Data_Memory.

---
 rtl/mem_write_buffer.sv | 216 +++++++++++++++++++++
 tb/tb_mem_write_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the dcache controller's line port and Data_Memory.
// Dirty-line writebacks are absorbed in one cycle and drained to memory in the background.
// Read misses bypass queued writes. Reads whose line is still buffered are served from the buffer.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   up_enable_i/up_write_i  upstream request valid (held until up_ack_o) and write select
//   up_addr_i/up_data_i     upstream byte address and write line
//   up_ack_o/up_data_o      one-cycle completion pulse and read line
//   dn_enable_o/dn_write_o  Data_Memory request (held until dn_ack_i) and write select
//   dn_addr_o/dn_data_o     Data_Memory line address (low bits zero) and write line
//   dn_ack_i/dn_data_i      Data_Memory completion pulse and read line
//   flush_i                 drain every entry before taking another upstream request
//   empty_o/count_o         buffer empty and idle; number of valid entries
module mem_write_buffer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned TAG_LSB = 5
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           up_enable_i,
  input  logic                           up_write_i,
  input  logic [31:0]                    up_addr_i,
  input  logic [LINE_W-1:0]              up_data_i,
  output logic                           up_ack_o,
  output logic [LINE_W-1:0]              up_data_o,
  output logic                           dn_enable_o,
  output logic                           dn_write_o,
  output logic [31:0]                    dn_addr_o,
  output logic [LINE_W-1:0]              dn_data_o,
  input  logic                           dn_ack_i,
  input  logic [LINE_W-1:0]              dn_data_i,
  input  logic                           flush_i,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned TagW = 32 - TAG_LSB;

  typedef enum logic [1:0] {StIdle, StRdMem, StWrMem, StResp} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [TagW-1:0]     tag_q  [DEPTH];
  logic [TagW-1:0]     tag_d  [DEPTH];
  logic [LINE_W-1:0]   data_q [DEPTH];
  logic [LINE_W-1:0]   data_d [DEPTH];

  logic                up_ack_q, up_ack_d;
  logic [LINE_W-1:0]   up_data_q, up_data_d;
  logic                dn_enable_q, dn_enable_d;
  logic                dn_write_q, dn_write_d;
  logic [31:0]         dn_addr_q, dn_addr_d;
  logic [LINE_W-1:0]   dn_data_q, dn_data_d;

  logic [TagW-1:0]     up_tag;
  logic                hit;
  logic [PtrW-1:0]     hit_idx;
  logic [PtrW-1:0]     scan_idx;
  logic                drain;
  logic                unused_addr_lsb;

  assign up_tag          = up_addr_i[31:TAG_LSB];
  assign unused_addr_lsb = ^up_addr_i[TAG_LSB-1:0];

  // Scan oldest to newest so the newest matching entry wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = head_q;
    scan_idx = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PtrW'(i);
      if (valid_q[scan_idx] && (tag_q[scan_idx] == up_tag)) begin
        hit     = 1'b1;
        hit_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    up_ack_d    = 1'b0;
    up_data_d   = up_data_q;
    dn_enable_d = dn_enable_q;
    dn_write_d  = dn_write_q;
    dn_addr_d   = dn_addr_q;
    dn_data_d   = dn_data_q;
    drain       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (flush_i && (count_q != '0)) begin
          drain = 1'b1;
        end else if (up_enable_i && !up_write_i) begin
          if (hit) begin
            up_data_d = data_q[hit_idx];
            up_ack_d  = 1'b1;
            state_d   = StResp;
          end else begin
            dn_enable_d = 1'b1;
            dn_write_d  = 1'b0;
            dn_addr_d   = {up_tag, {TAG_LSB{1'b0}}};
            state_d     = StRdMem;
          end
        end else if (up_enable_i) begin
          if (hit) begin
            // Coalesce; the head is never in flight while we are in IDLE.
            data_d[hit_idx] = up_data_i;
            up_ack_d        = 1'b1;
            state_d         = StResp;
          end else if (count_q < CntW'(DEPTH)) begin
            valid_d[tail_q] = 1'b1;
            tag_d[tail_q]   = up_tag;
            data_d[tail_q]  = up_data_i;
            tail_d          = tail_q + PtrW'(1);
            count_d         = count_q + CntW'(1);
            up_ack_d        = 1'b1;
            state_d         = StResp;
          end else begin
            // Full: free the head; the write stays pending and is retried in IDLE.
            drain = 1'b1;
          end
        end else if (count_q != '0) begin
          drain = 1'b1;
        end
      end
      StRdMem: begin
        if (dn_ack_i) begin
          up_data_d   = dn_data_i;
          up_ack_d    = 1'b1;
          dn_enable_d = 1'b0;
          state_d     = StResp;
        end
      end
      StWrMem: begin
        if (dn_ack_i) begin
          valid_d[head_q] = 1'b0;
          head_d          = head_q + PtrW'(1);
          count_d         = count_q - CntW'(1);
          dn_enable_d     = 1'b0;
          dn_write_d      = 1'b0;
          state_d         = StIdle;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (drain) begin
      dn_enable_d = 1'b1;
      dn_write_d  = 1'b1;
      dn_addr_d   = {tag_q[head_q], {TAG_LSB{1'b0}}};
      dn_data_d   = data_q[head_q];
      state_d     = StWrMem;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      up_ack_q    <= 1'b0;
      up_data_q   <= '0;
      dn_enable_q <= 1'b0;
      dn_write_q  <= 1'b0;
      dn_addr_q   <= '0;
      dn_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      up_ack_q    <= up_ack_d;
      up_data_q   <= up_data_d;
      dn_enable_q <= dn_enable_d;
      dn_write_q  <= dn_write_d;
      dn_addr_q   <= dn_addr_d;
      dn_data_q   <= dn_data_d;
    end
  end

  // Entry payload needs no reset; valid_q qualifies it.
  always_ff @(posedge clk_i) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign up_ack_o    = up_ack_q;
  assign up_data_o   = up_data_q;
  assign dn_enable_o = dn_enable_q;
  assign dn_write_o  = dn_write_q;
  assign dn_addr_o   = dn_addr_q;
  assign dn_data_o   = dn_data_q;
  assign count_o     = count_q;
  assign empty_o     = (count_q == '0) && (state_q == StIdle);

endmodule

// File: tb/tb_mem_write_buffer.sv
module tb_mem_write_buffer;

  localparam int unsigned LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_enable, up_write, dn_ack, flush;
  logic [31:0]   up_addr;
  logic [LW-1:0] up_data, dn_rdata;
  logic          up_ack, dn_en, dn_wr, empty;
  logic [LW-1:0] up_rdata, dn_wdata;
  logic [31:0]   dn_addr;
  logic [2:0]    count;

  mem_write_buffer #(.DEPTH(4), .LINE_W(LW), .TAG_LSB(5)) dut (
    .clk_i(clk), .rst_i(rst),
    .up_enable_i(up_enable), .up_write_i(up_write), .up_addr_i(up_addr), .up_data_i(up_data),
    .up_ack_o(up_ack), .up_data_o(up_rdata),
    .dn_enable_o(dn_en), .dn_write_o(dn_wr), .dn_addr_o(dn_addr), .dn_data_o(dn_wdata),
    .dn_ack_i(dn_ack), .dn_data_i(dn_rdata),
    .flush_i(flush), .empty_o(empty), .count_o(count)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic          ack_en;
  logic [LW-1:0] mem [128];
  logic [32:0]   ops [$];   // {write, addr} of every acknowledged memory access

  localparam logic [LW-1:0] LineA = {8{32'hAAAA_0001}};
  localparam logic [LW-1:0] LineB = {8{32'hBBBB_0002}};
  localparam logic [LW-1:0] LineC = {8{32'hCCCC_0003}};
  localparam logic [LW-1:0] LineE = {8{32'hEEEE_0005}};

  function automatic logic [LW-1:0] init_line(input int idx);
    return {8{32'(idx) ^ 32'hC0DE_0000}};
  endfunction

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Data_Memory model: acks an outstanding request one cycle after it appears.
  initial begin
    dn_ack   = 1'b0;
    dn_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (dn_ack) begin
        dn_ack = 1'b0;
      end else if (ack_en && dn_en && !rst) begin
        if (dn_wr) mem[dn_addr[11:5]] = dn_wdata;
        else dn_rdata = mem[dn_addr[11:5]];
        ops.push_back({dn_wr, dn_addr});
        dn_ack = 1'b1;
      end
    end
  end

  task automatic wait_ack(input int budget, output bit got, output logic [LW-1:0] rd,
                          output int cyc, output logic [2:0] cnt);
    got = 1'b0; rd = '0; cyc = 0; cnt = '0;
    while (!got && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (up_ack) begin
        got = 1'b1; rd = up_rdata; cnt = count;
      end
    end
  endtask

  // keep=1 leaves up_enable high so the caller can chain the next request into the RESP cycle.
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [LW-1:0] d,
                        input bit keep, output bit got, output logic [LW-1:0] rd,
                        output int cyc, output logic [2:0] cnt);
    up_enable = 1'b1; up_write = wr; up_addr = a; up_data = d;
    wait_ack(40, got, rd, cyc, cnt);
    if (!keep) up_enable = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int c = 0;
    while (!empty && c < 200) begin
      @(posedge clk); #1; c++;
    end
    check_eq(tag, LW'(empty), LW'(1));
  endtask

  task automatic wait_dn_write(output int c);
    c = 0;
    while (!(dn_en && dn_wr) && c < 10) begin
      @(posedge clk); #1; c++;
    end
  endtask

  initial begin
    bit            got;
    logic [LW-1:0] rd;
    int            cyc, n0, c;
    logic [2:0]    cnt;

    for (int i = 0; i < 128; i++) mem[i] = init_line(i);
    rst = 1'b1; up_enable = 1'b0; up_write = 1'b0; up_addr = '0; up_data = '0;
    flush = 1'b0; ack_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_up_ack", LW'(up_ack), '0);
    check_eq("rst_dn_en", LW'(dn_en), '0);
    check_eq("rst_dn_wr", LW'(dn_wr), '0);
    check_eq("rst_dn_addr", LW'(dn_addr), '0);
    check_eq("rst_dn_data", dn_wdata, '0);
    check_eq("rst_up_data", up_rdata, '0);
    check_eq("rst_empty", LW'(empty), LW'(1));
    check_eq("rst_count", LW'(count), '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: accepted write acks next cycle; drain appears within 2 cycles.
    ack_en = 1'b0;
    do_req(1'b1, 32'h400, LineA, 1'b0, got, rd, cyc, cnt);
    check_eq("t1_got", LW'(got), LW'(1));
    check_eq("t1_lat", LW'(cyc), LW'(1));
    check_eq("t1_count", LW'(cnt), LW'(1));
    wait_dn_write(c);
    check_eq("t1_drain_lat", LW'(c), LW'(2));
    check_eq("t1_dn_addr", LW'(dn_addr), LW'(32'h400));
    check_eq("t1_dn_data", dn_wdata, LineA);
    ack_en = 1'b1;
    wait_empty("t1_empty");
    check_eq("t1_mem", mem[32], LineA);

    // T2: read hit from the buffer; chained read spends one RESP cycle before IDLE sees it.
    ack_en = 1'b0;
    n0 = ops.size();
    do_req(1'b1, 32'h400, LineB, 1'b1, got, rd, cyc, cnt);
    do_req(1'b0, 32'h400, '0, 1'b0, got, rd, cyc, cnt);
    check_eq("t2_got", LW'(got), LW'(1));
    check_eq("t2_lat", LW'(cyc), LW'(2));
    check_eq("t2_data", rd, LineB);
    ack_en = 1'b1;
    wait_empty("t2_empty");
    check_eq("t2_nops", LW'(ops.size() - n0), LW'(1));
    check_eq("t2_op0", LW'(ops[n0]), LW'({1'b1, 32'h400}));

    // T4: coalescing writes to the same line.
    ack_en = 1'b0;
    n0 = ops.size();
    do_req(1'b1, 32'h020, LineA, 1'b1, got, rd, cyc, cnt);
    do_req(1'b1, 32'h020, LineB, 1'b0, got, rd, cyc, cnt);
    check_eq("t4_count", LW'(cnt), LW'(1));
    ack_en = 1'b1;
    wait_empty("t4_empty");
    check_eq("t4_mem", mem[1], LineB);
    check_eq("t4_nops", LW'(ops.size() - n0), LW'(1));

    // T3: full buffer stalls the fifth write until the head drains.
    ack_en = 1'b0;
    n0 = ops.size();
    for (int k = 0; k < 4; k++)
      do_req(1'b1, 32'(k * 32), {8{32'hD000_0000 + 32'(k)}}, 1'b1, got, rd, cyc, cnt);
    check_eq("t3_full", LW'(cnt), LW'(4));
    up_addr = 32'h080; up_data = LineE;
    wait_ack(10, got, rd, cyc, cnt);
    check_eq("t3_stalled", LW'(got), '0);
    ack_en = 1'b1;
    wait_ack(40, got, rd, cyc, cnt);
    up_enable = 1'b0;
    check_eq("t3_got", LW'(got), LW'(1));
    check_eq("t3_count", LW'(cnt), LW'(4));
    check_eq("t3_nops_at_ack", LW'(ops.size() - n0), LW'(1));
    check_eq("t3_op0", LW'(ops[n0]), LW'({1'b1, 32'h000}));
    wait_empty("t3_empty");
    check_eq("t3_op1", LW'(ops[n0+1]), LW'({1'b1, 32'h020}));
    check_eq("t3_op4", LW'(ops[n0+4]), LW'({1'b1, 32'h080}));
    check_eq("t3_mem", mem[4], LineE);

    // T5: read miss bypasses the queued 0x400 write.
    ack_en = 1'b0;
    n0 = ops.size();
    do_req(1'b1, 32'h400, LineC, 1'b1, got, rd, cyc, cnt);
    ack_en = 1'b1;
    do_req(1'b0, 32'h800, '0, 1'b0, got, rd, cyc, cnt);
    check_eq("t5_got", LW'(got), LW'(1));
    check_eq("t5_lat", LW'(cyc), LW'(3));
    check_eq("t5_data", rd, init_line(64));
    check_eq("t5_op0", LW'(ops[n0]), LW'({1'b0, 32'h800}));
    wait_empty("t5_empty");
    check_eq("t5_op1", LW'(ops[n0+1]), LW'({1'b1, 32'h400}));

    // T6: reset while in WR_MEM drops the buffered line.
    ack_en = 1'b0;
    do_req(1'b1, 32'h100, LineA, 1'b0, got, rd, cyc, cnt);
    wait_dn_write(c);
    check_eq("t6_in_wr", LW'(dn_en && dn_wr), LW'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_dn_en", LW'(dn_en), '0);
    check_eq("t6_count", LW'(count), '0);
    check_eq("t6_empty", LW'(empty), LW'(1));
    rst = 1'b0;
    ack_en = 1'b1;
    n0 = ops.size();
    repeat (5) @(posedge clk);
    #1;
    check_eq("t6_no_ops", LW'(ops.size() - n0), '0);
    check_eq("t6_mem", mem[8], init_line(8));

    // Flush: three queued writes drain in order before a pending read miss.
    ack_en = 1'b0;
    n0 = ops.size();
    do_req(1'b1, 32'h200, LineA, 1'b1, got, rd, cyc, cnt);
    do_req(1'b1, 32'h220, LineB, 1'b1, got, rd, cyc, cnt);
    do_req(1'b1, 32'h240, LineC, 1'b1, got, rd, cyc, cnt);
    check_eq("fl_count", LW'(cnt), LW'(3));
    flush = 1'b1;
    ack_en = 1'b1;
    do_req(1'b0, 32'h300, '0, 1'b0, got, rd, cyc, cnt);
    check_eq("fl_got", LW'(got), LW'(1));
    check_eq("fl_rdata", rd, init_line(24));
    check_eq("fl_op0", LW'(ops[n0]), LW'({1'b1, 32'h200}));
    check_eq("fl_op1", LW'(ops[n0+1]), LW'({1'b1, 32'h220}));
    check_eq("fl_op2", LW'(ops[n0+2]), LW'({1'b1, 32'h240}));
    check_eq("fl_op3", LW'(ops[n0+3]), LW'({1'b0, 32'h300}));
    wait_empty("fl_empty");
    check_eq("fl_count_end", LW'(count), '0);
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
